// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter: shares one single-port, synchronous-read pixel RAM between
// the VGA refresh path and a CPU request/acknowledge port. The video fetch owns
// the RAM in every p_tick clk; the CPU is granted any other clk while idle.
//
// CPU handshake: the master raises cpu_req with cpu_we/cpu_addr/cpu_wdata stable
// and holds it until it sees cpu_ack. The access is granted in the first idle
// clk without p_tick. cpu_ack pulses for exactly one clk, in the clk after the
// grant, and cpu_rdata is meaningful only in that clk. A request dropped early
// still completes; its ack is simply ignored by the master.
module vga_fb_arbiter #(
  parameter int H_RES  = 640,
  parameter int V_RES  = 480,
  parameter int SCALE  = 4,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_tick,
  input  logic [9:0]        pixel_x,
  input  logic [9:0]        pixel_y,
  input  logic              video_on,
  input  logic              hsync_in,
  input  logic              vsync_in,
  output logic              hsync,
  output logic              vsync,
  output logic [2:0]        rgb,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [2:0]        cpu_wdata,
  output logic [2:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [2:0]        mem_wdata,
  input  logic [2:0]        mem_rdata,
  output logic              fsm_state
);

  localparam int FB_W  = H_RES / SCALE;
  localparam int FB_H  = V_RES / SCALE;
  localparam int SHIFT = $clog2(SCALE);
  localparam logic [ADDR_W:0] FB_SIZE = (ADDR_W+1)'(FB_W * FB_H);

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } state_t;

  state_t            state;
  logic [9:0]        row;
  logic [9:0]        col;
  logic [ADDR_W-1:0] video_addr;
  logic              in_range;
  logic              grant;
  logic              acc_read;
  logic              fetch_d;
  logic [2:0]        pix_buf;
  logic              vid_d;
  logic              hs_d;
  logic              vs_d;

  // Framebuffer address of the current pixel: row*FB_W built from shifted
  // copies of row, one per set bit of FB_W, so no multiplier is inferred.
  always_comb begin
    row        = pixel_y >> SHIFT;
    col        = pixel_x >> SHIFT;
    video_addr = ADDR_W'(col);
    for (int i = 0; i < ADDR_W; i++) begin
      if (FB_W[i]) video_addr = video_addr + (ADDR_W'(row) << i);
    end
  end

  // CPU grant: idle FSM, pending request, no video slot, not in reset.
  always_comb begin
    in_range = {1'b0, cpu_addr} < FB_SIZE;
    grant    = reset && (state == IDLE) && cpu_req && !p_tick;
  end

  // RAM port mux: the grant clk belongs to the CPU, every other clk presents
  // the video address as a read (the p_tick clk is the one that matters).
  always_comb begin
    mem_addr  = grant ? cpu_addr : video_addr;
    mem_we    = grant && cpu_we && in_range;
    mem_wdata = cpu_wdata;
  end

  // CPU FSM: grant in IDLE, one-clk acknowledge in ACK, then back to IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cpu_ack  <= 1'b0;
      acc_read <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state    <= ACK;
            cpu_ack  <= 1'b1;
            acc_read <= !cpu_we && in_range;
          end
        end
        ACK: begin
          state    <= IDLE;
          cpu_ack  <= 1'b0;
          acc_read <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          cpu_ack  <= 1'b0;
          acc_read <= 1'b0;
        end
      endcase
    end
  end

  // Read data arrives from the RAM during the ACK clk; out-of-range reads
  // and writes return zero.
  always_comb begin
    cpu_rdata = acc_read ? mem_rdata : 3'b000;
    fsm_state = state;
  end

  // Video pipe: capture the fetched pixel and its sync/visibility flags the
  // clk after p_tick, then present them together at the following p_tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_d <= 1'b0;
      pix_buf <= 3'b000;
      vid_d   <= 1'b0;
      hs_d    <= 1'b0;
      vs_d    <= 1'b0;
      rgb     <= 3'b000;
      hsync   <= 1'b0;
      vsync   <= 1'b0;
    end else begin
      fetch_d <= p_tick;
      if (fetch_d) begin
        pix_buf <= mem_rdata;
        vid_d   <= video_on;
        hs_d    <= hsync_in;
        vs_d    <= vsync_in;
      end
      if (p_tick) begin
        rgb   <= vid_d ? pix_buf : 3'b000;
        hsync <= hs_d;
        vsync <= vs_d;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Bench for vga_fb_arbiter: directed literal cases followed by random video
// ticks and back-to-back CPU traffic, checked every clk against a pixel-level
// model (RAM contents, one-pixel output lag, grant-in-first-free-clk rule).
module tb_vga_fb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        p_tick;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        video_on;
  logic        hsync_in;
  logic        vsync_in;
  logic        hsync;
  logic        vsync;
  logic [2:0]  rgb;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [2:0]  cpu_wdata;
  logic [2:0]  cpu_rdata;
  logic        cpu_ack;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [2:0]  mem_wdata;
  logic [2:0]  mem_rdata;
  logic        fsm_state;

  int total = 0;
  int bad   = 0;

  // clock / reset block
  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk(clk), .reset(reset), .p_tick(p_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .hsync(hsync), .vsync(vsync), .rgb(rgb),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .fsm_state(fsm_state)
  );

  // Physical RAM the DUT talks to (synchronous read, write on mem_we).
  logic [2:0] ram [0:32767];
  always @(posedge clk) begin
    mem_rdata <= ram[mem_addr];
    if (mem_we) ram[mem_addr] <= mem_wdata;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: framebuffer contents plus the pixel/ack pipeline seen
  // from the outside.
  logic [2:0] ref_mem [0:19199];
  logic       mon_en   = 1'b0;
  logic       ack_seen = 1'b0;
  logic       ack_due  = 1'b0;
  logic       ack_rd   = 1'b0;
  logic [2:0] ack_data = 3'b0;
  logic [2:0] cur_rgb  = 3'b0;
  logic       cur_hs   = 1'b0;
  logic       cur_vs   = 1'b0;
  logic [2:0] prev_rgb = 3'b0;
  logic       prev_hs  = 1'b0;
  logic       prev_vs  = 1'b0;

  // Scoreboard compare process: every clk after reset release.
  always @(negedge clk) begin
    int  va;
    int  ca;
    logic due_next;
    if (mon_en) begin
      chk("rgb", rgb, cur_rgb);
      chk("hsync", hsync, cur_hs);
      chk("vsync", vsync, cur_vs);
      due_next = 1'b0;
      if (p_tick) begin
        va = (int'(pixel_y) / 4) * 160 + int'(pixel_x) / 4;
        chk("video_addr", mem_addr, va);
        chk("video_no_we", mem_we, 0);
        cur_rgb  = prev_rgb;
        cur_hs   = prev_hs;
        cur_vs   = prev_vs;
        prev_rgb = video_on ? ref_mem[va] : 3'b000;
        prev_hs  = hsync_in;
        prev_vs  = vsync_in;
      end
      chk("cpu_ack", cpu_ack, ack_due);
      if (ack_due && ack_rd) chk("cpu_rdata", cpu_rdata, ack_data);
      if (!ack_due && cpu_req && !p_tick) begin
        ca = int'(cpu_addr);
        chk("grant_addr", mem_addr, cpu_addr);
        chk("grant_we", mem_we, cpu_we && ca < 19200);
        if (cpu_we) begin
          chk("grant_wdata", mem_wdata, cpu_wdata);
          if (ca < 19200) ref_mem[ca] = cpu_wdata;
          ack_rd = 1'b0;
        end else begin
          ack_rd   = 1'b1;
          ack_data = (ca < 19200) ? ref_mem[ca] : 3'b000;
        end
        due_next = 1'b1;
      end else if (!p_tick) begin
        chk("idle_no_we", mem_we, 0);
      end
      ack_due  = due_next;
      ack_seen = cpu_ack;
    end
  end

  // driver tasks
  task automatic tick(input int x, input int y, input logic vid, input logic hs, input logic vs,
                      output logic [14:0] addr_at_tick);
    @(posedge clk); #1;
    p_tick = 1'b1; pixel_x = 10'(x); pixel_y = 10'(y);
    video_on = vid; hsync_in = hs; vsync_in = vs;
    @(negedge clk);
    addr_at_tick = mem_addr;
    @(posedge clk); #1;
    p_tick = 1'b0;
  endtask

  task automatic cpu_op(input logic we, input int addr, input logic [2:0] data,
                        input logic exp_we, output logic [2:0] rd);
    @(posedge clk); #1;
    p_tick = 1'b0; cpu_req = 1'b1; cpu_we = we; cpu_addr = 15'(addr); cpu_wdata = data;
    @(negedge clk);
    chk("op_mem_we", mem_we, exp_we);
    chk("op_mem_addr", mem_addr, addr);
    chk("op_no_early_ack", cpu_ack, 0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("op_ack", cpu_ack, 1);
    rd = cpu_rdata;
  endtask

  task automatic new_op();
    cpu_req   = 1'b1;
    cpu_we    = 1'($urandom_range(0, 1));
    cpu_addr  = ($urandom_range(0, 15) == 0) ? 15'($urandom_range(19200, 32767))
                                             : 15'($urandom_range(0, 19199));
    cpu_wdata = 3'($urandom_range(0, 7));
  endtask

  initial begin
    logic [14:0] ta;
    logic [2:0]  rd;
    int          ops;
    int          cyc;
    int          idle_left;

    for (int i = 0; i < 32768; i++) ram[i] = 3'($urandom_range(0, 7));
    for (int i = 0; i < 19200; i++) ref_mem[i] = ram[i];

    reset = 1'b0; p_tick = 1'b0; pixel_x = '0; pixel_y = '0; video_on = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 15'd7; cpu_wdata = 3'd5;

    // reset held 3 clk with a pending CPU write
    repeat (3) begin
      @(negedge clk);
      chk("rst_rgb", rgb, 0);
      chk("rst_ack", cpu_ack, 0);
      chk("rst_mem_we", mem_we, 0);
    end
    @(posedge clk); #1;
    reset = 1'b1; cpu_req = 1'b0; mon_en = 1'b1;
    @(negedge clk);
    chk("fsm_idle_after_reset", fsm_state, 0);

    // CPU writes in non-tick clks
    cpu_op(1'b1, 5, 3'b011, 1'b1, rd);
    cpu_op(1'b1, 162, 3'b101, 1'b1, rd);

    // pixel (8,4) -> address 162, shown one pixel later
    tick(8, 4, 1'b1, 1'b0, 1'b0, ta);
    chk("tick_addr_162", ta, 162);
    tick(0, 0, 1'b0, 1'b1, 1'b0, ta);
    @(negedge clk);
    chk("rgb_101", rgb, 3'b101);
    chk("hsync_not_yet", hsync, 0);
    tick(8, 4, 1'b0, 1'b1, 1'b0, ta);
    @(negedge clk);
    chk("hsync_delayed", hsync, 1);
    tick(0, 0, 1'b0, 1'b0, 1'b0, ta);
    @(negedge clk);
    chk("rgb_blank", rgb, 3'b000);

    // read requested in a tick clk: deferred one clk
    @(posedge clk); #1;
    p_tick = 1'b1; pixel_x = 10'd0; pixel_y = 10'd0; video_on = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'd162;
    @(negedge clk);
    chk("defer_video_addr", mem_addr, 0);
    chk("defer_no_ack", cpu_ack, 0);
    @(posedge clk); #1;
    p_tick = 1'b0;
    @(negedge clk);
    chk("defer_grant_addr", mem_addr, 162);
    @(posedge clk); #1;
    @(negedge clk);
    chk("defer_ack", cpu_ack, 1);
    chk("defer_rdata", cpu_rdata, 3'b101);
    @(posedge clk); #1;
    cpu_req = 1'b0;

    // out-of-range accesses
    cpu_op(1'b1, 19200, 3'b111, 1'b0, rd);
    cpu_op(1'b0, 19200, 3'b000, 1'b0, rd);
    chk("oor_rdata", rd, 0);

    // random video ticks with back-to-back CPU traffic
    ops = 0; cyc = 0; idle_left = 0;
    while (ops < 100 && cyc < 5000) begin
      @(posedge clk); #1;
      cyc++;
      if (p_tick) begin
        p_tick    = 1'b0;
        idle_left = ($urandom_range(0, 4) == 0) ? 1 : 0;
      end else if (idle_left > 0) begin
        idle_left--;
      end else begin
        p_tick   = 1'b1;
        pixel_x  = 10'($urandom_range(0, 639));
        pixel_y  = 10'($urandom_range(0, 479));
        video_on = ($urandom_range(0, 7) != 0);
        hsync_in = 1'($urandom_range(0, 1));
        vsync_in = 1'($urandom_range(0, 1));
      end
      if (cpu_req && ack_seen) begin
        ops++;
        if ($urandom_range(0, 3) != 0) new_op();
        else cpu_req = 1'b0;
      end else if (!cpu_req && $urandom_range(0, 1) == 1) begin
        new_op();
      end
    end
    chk("random_ops_done", ops >= 100, 1);

    @(posedge clk); #1;
    cpu_req = 1'b0; p_tick = 1'b0;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
